// File: rtl/coffee_brewer_pkg.sv
// rtl/coffee_brewer_pkg.sv - shared kind codes, cup limit and state encodings for the brewer
package coffee_brewer_pkg;

    localparam logic [1:0] KIND_AMERICANO = 2'b01;
    localparam logic [1:0] KIND_RATTE     = 2'b10;
    localparam int         MAX_CUPS       = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_POUR    = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4,
        ST_RELEASE = 3'd5,
        ST_FAULT   = 3'd6
    } state_e;

    // Counter holds at most (largest phase length - 1); keep at least one bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/brew_timer.sv
// rtl/brew_timer.sv - loadable down-counter with zero flag timing the brew phases
module brew_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/coffee_brewer.sv
// rtl/coffee_brewer.sv - Making/Done/TakeOut responder: warm up, pour cups, hold Done until taken
module coffee_brewer
    import coffee_brewer_pkg::*;
#(
    parameter int WARMUP_CYC = 4,
    parameter int AMER_CYC   = 6,
    parameter int RATTE_CYC  = 10,
    parameter int GAP_CYC    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Making,
    input  logic [1:0] Kind,
    input  logic [2:0] Cups,
    input  logic       TakeOut,
    output logic       Done,
    output logic       Busy,
    output logic       Pour,
    output logic       Fault,
    output logic [2:0] CupCount
);

    localparam int         CNT_W      = cnt_width(WARMUP_CYC, AMER_CYC, RATTE_CYC, GAP_CYC);
    localparam logic [2:0] MAX_CUPS_C = 3'(MAX_CUPS);

    state_e       state_q, state_d;
    logic [1:0]   kind_q, kind_d;
    logic [2:0]   cups_q, cups_d;
    logic [2:0]   cup_count_q, cup_count_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         pour_q, pour_d;
    logic         fault_q, fault_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;
    logic             legal;
    logic [2:0]       next_cup;
    logic [CNT_W-1:0] pour_ld;

    brew_timer #(.W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign legal    = ((Kind == KIND_AMERICANO) || (Kind == KIND_RATTE)) &&
                      (Cups != 3'd0) && (Cups <= MAX_CUPS_C);
    assign next_cup = cup_count_q + 3'd1;
    assign pour_ld  = (kind_q == KIND_RATTE) ? CNT_W'(RATTE_CYC - 1) : CNT_W'(AMER_CYC - 1);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cups_d      = cups_q;
        cup_count_d = cup_count_q;
        timer_load  = 1'b0;
        timer_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (Making) begin
                    if (legal) begin
                        kind_d      = Kind;
                        cups_d      = Cups;
                        cup_count_d = 3'd0;
                        timer_load  = 1'b1;
                        timer_val   = CNT_W'(WARMUP_CYC - 1);
                        state_d     = ST_WARMUP;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WARMUP: begin
                if (!Making) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = pour_ld;
                    state_d    = ST_POUR;
                end
            end
            ST_POUR: begin
                if (!Making) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    cup_count_d = next_cup;
                    if (next_cup == cups_q) begin
                        state_d = ST_DONE;
                    end else begin
                        timer_load = 1'b1;
                        timer_val  = CNT_W'(GAP_CYC - 1);
                        state_d    = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!Making) begin
                    state_d = ST_IDLE;
                end else if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = pour_ld;
                    state_d    = ST_POUR;
                end
            end
            ST_DONE: begin
                // Skip RELEASE when the request has already been withdrawn.
                if (TakeOut) begin
                    state_d = Making ? ST_RELEASE : ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!Making) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (!Making) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_WARMUP) || (state_d == ST_POUR) || (state_d == ST_GAP);
        pour_d  = (state_d == ST_POUR);
        done_d  = (state_d == ST_DONE);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            kind_q      <= 2'b00;
            cups_q      <= 3'd0;
            cup_count_q <= 3'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            pour_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cups_q      <= cups_d;
            cup_count_q <= cup_count_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            pour_q      <= pour_d;
            fault_q     <= fault_d;
        end
    end

    assign Done     = done_q;
    assign Busy     = busy_q;
    assign Pour     = pour_q;
    assign Fault    = fault_q;
    assign CupCount = cup_count_q;

endmodule
